// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the M-extension unit: ALU SELECT codes, FSM states,
// multiplier latency bounds and opcode-class helpers.
package muldiv_unit_pkg;

   localparam logic [4:0] SEL_MUL    = 5'h08;
   localparam logic [4:0] SEL_MULH   = 5'h09;
   localparam logic [4:0] SEL_MULHSU = 5'h0A;
   localparam logic [4:0] SEL_MULHU  = 5'h0B;
   // Divide codes: bit 0 set = unsigned, bit 1 set = remainder.
   localparam logic [4:0] SEL_DIV    = 5'h0C;
   localparam logic [4:0] SEL_DIVU   = 5'h0D;
   localparam logic [4:0] SEL_REM    = 5'h0E;
   localparam logic [4:0] SEL_REMU   = 5'h0F;

   localparam int MUL_LAT_MIN = 1;
   localparam int MUL_LAT_MAX = 4;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   function automatic logic is_mul(input logic [4:0] s);
      return s inside {SEL_MUL, SEL_MULH, SEL_MULHSU, SEL_MULHU};
   endfunction

   function automatic logic is_div(input logic [4:0] s);
      return s inside {SEL_DIV, SEL_DIVU, SEL_REM, SEL_REMU};
   endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divide core on unsigned magnitudes, one quotient bit per step.
// done flags the step that produces the final quotient bit.
module muldiv_unit_div_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quo,
   output logic [XLEN-1:0] rem,
   output logic            done
);
   localparam int CW = $clog2(XLEN + 1);

   logic [XLEN-1:0] q_r, r_r, d_r;
   logic [CW-1:0]   cnt;
   logic [XLEN:0]   shifted, diff;

   // Dividend bits shift out of the quotient register into the partial remainder.
   assign shifted = {r_r, q_r[XLEN-1]};
   assign diff    = shifted - {1'b0, d_r};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= '0;
         r_r <= '0;
         d_r <= '0;
         cnt <= '0;
      end else if (load) begin
         q_r <= dividend;
         r_r <= '0;
         d_r <= divisor;
         cnt <= '0;
      end else if (step) begin
         cnt <= cnt + 1'b1;
         if (!diff[XLEN]) begin
            r_r <= diff[XLEN-1:0];
            q_r <= {q_r[XLEN-2:0], 1'b1};
         end else begin
            r_r <= shifted[XLEN-1:0];
            q_r <= {q_r[XLEN-2:0], 1'b0};
         end
      end
   end

   assign quo  = q_r;
   assign rem  = r_r;
   assign done = step && (cnt == CW'(XLEN - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension unit: pipelined multiply, iterative divide.
// Define MULDIV_REM_CACHE_EN to reuse the last normal divide's quotient/remainder.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [4:0]      select,
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   input  logic            kill,
   output logic [XLEN-1:0] result,
   output logic            valid,
   output logic            busy
);
   localparam int              PW       = 2 * XLEN;
   localparam logic [1:0]      MUL_END  = 2'(MUL_LAT - 2);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t               state, nstate;
   logic                 accept, sel_mul, sel_div, d_sgn, d_rem;
   logic                 div_zero, div_ovf, special, hit, fast;
   logic                 div_load, div_step, div_done;
   logic                 op_hi, op_rem, neg_q, neg_r;
   logic [1:0]           mul_cnt;
   logic signed [XLEN:0] ma, mb;
   logic [PW-1:0]        mprod, mul_out;
   logic [XLEN-1:0]      fast_res, abs1, abs2, quo, rem, q_fix, r_fix, c_q, c_r;

   assign busy    = (state != IDLE);
   assign accept  = start && !busy && !kill;
   assign sel_mul = is_mul(select);
   assign sel_div = is_div(select);
   assign d_sgn   = !select[0];
   assign d_rem   = select[1];

   assign div_zero = (data2 == '0);
   assign div_ovf  = d_sgn && (data1 == MOST_NEG) && (data2 == '1);
   assign special  = div_zero || div_ovf;
   assign div_load = accept && sel_div && !special && !hit;
   assign fast     = accept && !div_load && !(sel_mul && (MUL_LAT > 1));

   // Multiply: XLEN+1-bit operands cover all signed/unsigned mixes with one signed multiplier.
   assign ma    = {(select != SEL_MULHU) & data1[XLEN-1], data1};
   assign mb    = {((select == SEL_MUL) || (select == SEL_MULH)) & data2[XLEN-1], data2};
   assign mprod = PW'(ma) * PW'(mb);

   generate
      if (MUL_LAT == 1) begin : g_mul_comb
         assign mul_out = mprod;
      end else begin : g_mul_pipe
         logic [MUL_LAT-2:0][PW-1:0] preg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               preg <= '0;
            end else begin
               preg[0] <= mprod;
               for (int i = 1; i < MUL_LAT - 1; i++) preg[i] <= preg[i-1];
            end
         end
         assign mul_out = preg[MUL_LAT-2];
      end
   endgenerate

   // Divide on magnitudes; the FIX state restores signs.
   assign abs1  = (d_sgn && data1[XLEN-1]) ? -data1 : data1;
   assign abs2  = (d_sgn && data2[XLEN-1]) ? -data2 : data2;
   assign div_step = (state == DIV);
   assign q_fix = neg_q ? -quo : quo;
   assign r_fix = neg_r ? -rem : rem;

   muldiv_unit_div_iter #(.XLEN(XLEN)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (div_load),
      .step     (div_step),
      .dividend (abs1),
      .divisor  (abs2),
      .quo      (quo),
      .rem      (rem),
      .done     (div_done)
   );

`ifdef MULDIV_REM_CACHE_EN
   logic [XLEN-1:0] c_d1, c_d2, op_d1, op_d2;
   logic            c_sgn, c_vld, op_sgn;

   assign hit = c_vld && (c_d1 == data1) && (c_d2 == data2) && (c_sgn == d_sgn);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_vld  <= 1'b0;
         c_sgn  <= 1'b0;
         c_d1   <= '0;
         c_d2   <= '0;
         c_q    <= '0;
         c_r    <= '0;
         op_d1  <= '0;
         op_d2  <= '0;
         op_sgn <= 1'b0;
      end else begin
         if (div_load) begin
            op_d1  <= data1;
            op_d2  <= data2;
            op_sgn <= d_sgn;
         end
         if (state == FIX && !kill) begin
            c_vld <= 1'b1;
            c_sgn <= op_sgn;
            c_d1  <= op_d1;
            c_d2  <= op_d2;
            c_q   <= q_fix;
            c_r   <= r_fix;
         end
      end
   end
`else
   assign hit = 1'b0;
   assign c_q = '0;
   assign c_r = '0;
`endif

   // Single-cycle results: multiply at MUL_LAT=1, divide special cases, cache hits, non-M codes.
   always_comb begin
      fast_res = '0;
      if (sel_mul) begin
         fast_res = (select == SEL_MUL) ? mprod[XLEN-1:0] : mprod[PW-1:XLEN];
      end else if (sel_div) begin
         if (div_zero)     fast_res = d_rem ? data1 : '1;
         else if (div_ovf) fast_res = d_rem ? '0 : data1;
         else              fast_res = d_rem ? c_r : c_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE: begin
            if (div_load)                               nstate = DIV;
            else if (accept && sel_mul && (MUL_LAT > 1)) nstate = MUL;
         end
         MUL:     if (kill || (mul_cnt == MUL_END)) nstate = IDLE;
         DIV: begin
            if (kill)          nstate = IDLE;
            else if (div_done) nstate = FIX;
         end
         FIX:     nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result  <= '0;
         valid   <= 1'b0;
         mul_cnt <= '0;
         op_hi   <= 1'b0;
         op_rem  <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else begin
         valid <= 1'b0;
         unique case (state)
            IDLE: if (accept) begin
               op_hi   <= (select != SEL_MUL);
               op_rem  <= d_rem;
               neg_q   <= d_sgn && (data1[XLEN-1] ^ data2[XLEN-1]);
               neg_r   <= d_sgn && data1[XLEN-1];
               mul_cnt <= '0;
               if (fast) begin
                  result <= fast_res;
                  valid  <= 1'b1;
               end
            end
            MUL: if (!kill) begin
               mul_cnt <= mul_cnt + 2'd1;
               if (mul_cnt == MUL_END) begin
                  result <= op_hi ? mul_out[PW-1:XLEN] : mul_out[XLEN-1:0];
                  valid  <= 1'b1;
               end
            end
            FIX: if (!kill) begin
               result <= op_rem ? r_fix : q_fix;
               valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle M-extension execution unit in the EX stage, beside the single-cycle ALU.
- Takes the MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU opcodes off the combinational path.
- Multiply uses a configurable-latency pipelined multiplier; divide uses an iterative radix-2 core.
- Start/busy/valid handshake lets the hazard unit stall the pipeline; implements RISC-V divide-by-zero and overflow semantics.

Parameters:
- XLEN, 32, operand and result width (even, at least 8).
- MUL_LAT, 2, cycles from START to VALID for multiply ops (1..4).

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only when BUSY=0.
- SELECT  input  5  opcode, using the shared ALU SELECT encodings.
- DATA1  input  XLEN  rs1 operand.
- DATA2  input  XLEN  rs2 operand.
- KILL  input  1  flush; aborts any in-flight operation.
- RESULT  output  XLEN  registered result, held until the next VALID.
- VALID  output  1  one-cycle pulse; RESULT is valid.
- BUSY  output  1  operation in flight; the stall request.

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE, RESULT=0, VALID=0, BUSY=0, divider registers cleared. Reset asserted mid-operation discards the operation with no VALID.
- Acceptance: START=1 with BUSY=0 at edge k latches SELECT, DATA1 and DATA2. START while BUSY=1 is ignored.
- Latency L:
  - BUSY=1 in cycles k+1 .. k+L-1.
  - VALID=1 in cycle k+L, with BUSY=0 in that cycle.
  - A new START is accepted in the VALID cycle, giving back-to-back operation.
- Latency per op:
  - Multiply ops: L=MUL_LAT.
  - Divide special cases: L=1.
  - Normal divide: L=XLEN+2.
  - Non-M SELECT: L=1, RESULT=0.
- States: IDLE, MUL, DIV, FIX. Transitions:
  - IDLE -> MUL on a multiply START.
  - IDLE -> DIV on a normal divide START.
  - IDLE stays IDLE (VALID next cycle) for special cases.
  - MUL -> IDLE after MUL_LAT-1 cycles.
  - DIV -> FIX after XLEN iterations.
  - FIX -> IDLE (sign correction, VALID).
- Multiply:
  - Operands extended to XLEN+1 bits: signed for MUL, MULH and DATA1 of MULHSU; zero-extended otherwise.
  - Full 2*XLEN product.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide:
  - Magnitudes are computed for signed ops.
  - Restoring division, one quotient bit per cycle, over XLEN cycles.
  - FIX negates the quotient if the operand signs differ, and negates the remainder if DATA1 is negative.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases, detected in the START cycle:
  - DATA2=0: quotient is all-ones; remainder equals DATA1.
  - Signed, DATA1=most-negative and DATA2=all-ones: quotient equals DATA1; remainder is 0.
- KILL:
  - In-flight: state returns to IDLE on the next edge; VALID is suppressed and RESULT keeps its old value. BUSY is 0 in the following cycle.
  - Concurrent with START: the START is dropped.
  - In the VALID cycle: VALID still fires, because it is already registered.

Optional Feature:
- MULDIV_REM_CACHE_EN defined:
  - Registers the last completed normal divide: DATA1, DATA2, signedness, quotient and remainder, plus a cache-valid bit.
  - A divide-class START whose operands and signedness match a valid entry completes with L=1, returning the cached quotient or remainder. This covers DIV followed by REM.
  - Cache-valid is cleared by reset. A killed divide does not update the cache.
- Undefined: no cache storage; every normal divide takes XLEN+2 cycles.

Decomposition:
- Shared encodings include: the existing SELECT codes, plus the state localparams (IDLE/MUL/DIV/FIX) and the MUL_LAT bounds.
- One sub-module, div_iter: a radix-2 restoring core with load/step/done, parametrised by XLEN.
- The multiplier pipeline stays inline.

Test Plan (XLEN=32, MUL_LAT=2):
- MUL with 7 and 0xFFFFFFFD: RESULT=0xFFFFFFEB, VALID at k+2, BUSY high in k+1 only.
- Multiply high variants:
  - MULH 0x80000000×0x80000000 gives 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
  - Issued back-to-back with START in each VALID cycle.
- Normal divide of 0xFFFFFFF9 by 2:
  - DIV gives 0xFFFFFFFD at k+34.
  - The following REM gives 0xFFFFFFFF: at k+34 without the cache, at k+1 with MULDIV_REM_CACHE_EN.
- Special cases, all VALID at k+1:
  - DIVU 5/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM with the same operands gives 0.
- KILL during a DIV at k+10: no VALID, BUSY=0 at k+11, RESULT unchanged; a new MUL START at k+11 completes at k+13.
- Busy and reset:
  - START pulsed while BUSY is ignored, and the original result is returned.
  - RESET driven low mid-divide clears all outputs immediately (asynchronously); no VALID follows release.
